opn_write_sequencer: RTL and testbench
======================================

OPN_WRITE_SEQUENCER -- requirements
Module: opn_write_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries; power of two, 2..16.
REQ-002 Parameter STROBE_LEN, default 2: cen ticks that wr_n is held low per strobe.
REQ-003 Parameter ADDR_WAIT, default 6: idle cen ticks after an address write.
REQ-004 Parameter WAIT_PSG, default 6: idle cen ticks after a data write to register 0x00-0x0F.
REQ-005 Parameter WAIT_FM, default 24: idle cen ticks after a data write to any other register.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 cen  in  1  clock enable shared with the sound chip; all timing counts cen-high cycles.
REQ-009 cmd_valid  in  1  host offers a register write.
REQ-010 cmd_reg  in  8  target chip register number.
REQ-011 cmd_data  in  8  value to write.
REQ-012 cmd_ready  out  1  FIFO can accept; a command transfers when cmd_valid and cmd_ready are both high at a clk edge.
REQ-013 chip_cs_n  out  1  chip select to the sound chip.
REQ-014 chip_wr_n  out  1  write strobe to the sound chip.
REQ-015 chip_addr  out  1  A0: 0 = address cycle, 1 = data cycle.
REQ-016 chip_din  out  8  data bus to the sound chip.
REQ-017 busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
REQ-018 done  out  1  one-clk pulse when a command's final wait finishes.
REQ-019 level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-020 FIFO: FWFT, stores {reg,data}; cmd_ready = !full; a push and a pop in the same cycle are both honoured when the FIFO is non-full and non-empty; when full, a push is refused even if a pop occurs that cycle.
REQ-021 FSM states: IDLE, A_SETUP, A_STROBE, A_HOLD, A_WAIT, D_SETUP, D_STROBE, D_HOLD, D_WAIT.
REQ-022 IDLE -> A_SETUP on a clk edge with FIFO non-empty, regardless of cen; the head entry is popped into a command latch on that edge.
REQ-023 Each other state lasts a fixed number of cen-high cycles: SETUP 1, STROBE STROBE_LEN, HOLD 1, A_WAIT ADDR_WAIT, D_WAIT WAIT_PSG or WAIT_FM; while cen=0 the state, the counter and all outputs hold.
REQ-024 In A_*: chip_addr=0, chip_din=latched reg. In D_*: chip_addr=1, chip_din=latched data.
REQ-025 chip_cs_n=0 in SETUP, STROBE and HOLD; otherwise 1. chip_wr_n=0 only in STROBE.
REQ-026 D_WAIT length: WAIT_PSG if the latched reg < 0x10, else WAIT_FM; a wait parameter of 0 skips the wait state.
REQ-027 When D_WAIT ends: done=1 for one clk; go to A_SETUP with a new pop if the FIFO is non-empty on that edge (back-to-back), else to IDLE.
REQ-028 The wait counter is wide enough for max(ADDR_WAIT, WAIT_PSG, WAIT_FM, STROBE_LEN) with no wrap; the data written to the chip never depends on wait timing.
REQ-029 chip_din and chip_addr are stable from SETUP through HOLD; all chip_* outputs are registered, with no combinational path from cmd_* inputs.

Reset
REQ-030 While rst=0 at a clk edge: FSM to IDLE, FIFO emptied, chip_cs_n=1, chip_wr_n=1, chip_addr=0, chip_din=0x00, done=0, busy=0, level=0, cmd_ready=0.
REQ-031 Reset taken mid-strobe releases chip_wr_n and chip_cs_n on that same edge; the interrupted command is discarded, not retried.
REQ-032 cmd_ready returns to 1 on the first clk after rst returns to 1.

Structure
REQ-033 A shared package holds the FSM state enum, the PSG/FM register boundary constant 0x10 and the default timing constants.
REQ-034 The FIFO is a separate sub-module, opn_cmd_fifo; the FSM and wait counter live in the top module.

Verification
REQ-035 cen=1, push {0x28,0xF0} -> A phase: cs_n low for 4 clk with din=0x28, wr_n low for exactly 2 clk; data phase follows 6 clk later with din=0xF0 and A0=1; done pulses 24 clk after the data-phase cs_n rises.
REQ-036 Push {0x07,0x38} -> data-phase wait is 6 clk (PSG); total push-to-done is 21 clk.
REQ-037 Push 5 commands in 5 consecutive clk with FIFO_DEPTH=4 -> commands 1-5 accepted (the first is popped immediately); a 6th push is stalled with cmd_ready=0 until the next pop; outputs are back-to-back with no IDLE cycle between commands, and done pulses 5 times.
REQ-038 cen toggling 1/0 every clk -> every phase lasts twice as many clk as with cen=1; the strobe sequence is otherwise identical.
REQ-039 Assert rst during D_STROBE -> next edge: wr_n=1, cs_n=1, level=0, no done pulse; a new command after reset runs normally.

Source files
------------

// File: rtl/opn_write_sequencer_pkg.sv
// Shared types and constants for the OPN register-write sequencer.
// Holds the FSM state encoding, the PSG/FM register boundary and default timings.
package opn_write_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SETUP,
    S_A_STROBE,
    S_A_HOLD,
    S_A_WAIT,
    S_D_SETUP,
    S_D_STROBE,
    S_D_HOLD,
    S_D_WAIT
  } state_t;

  // Registers below this number belong to the SSG/PSG block and recover faster.
  localparam logic [7:0] PSG_FM_BOUNDARY = 8'h10;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_STROBE_LEN = 2;
  localparam int DEF_ADDR_WAIT  = 6;
  localparam int DEF_WAIT_PSG   = 6;
  localparam int DEF_WAIT_FM    = 24;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/opn_write_sequencer_fifo.sv
// First-word-fall-through command FIFO holding {reg,data} pairs.
// ready is held low through reset and for the reset edge itself.
module opn_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             ready_en;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign ready   = ready_en && !full;
  assign push_ok = push && ready;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/opn_write_sequencer.sv
// Queues host register writes and replays them to an OPN-family sound chip as
// address/data bus cycles with cen-paced strobes and post-write recovery waits.
//
// state      | meaning
// IDLE       | nothing in flight, waits for a queued command
// A_SETUP    | cs_n low, A0=0, register number on the bus
// A_STROBE   | wr_n low for STROBE_LEN cen ticks (address)
// A_HOLD     | wr_n released, cs_n still low
// A_WAIT     | chip busy after address write
// D_SETUP    | cs_n low, A0=1, data value on the bus
// D_STROBE   | wr_n low for STROBE_LEN cen ticks (data)
// D_HOLD     | wr_n released, cs_n still low
// D_WAIT     | chip busy after data write (PSG or FM length)
module opn_write_sequencer
  import opn_write_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int STROBE_LEN = DEF_STROBE_LEN,
  parameter int ADDR_WAIT  = DEF_ADDR_WAIT,
  parameter int WAIT_PSG   = DEF_WAIT_PSG,
  parameter int WAIT_FM    = DEF_WAIT_FM
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cen,
  input  logic                          cmd_valid,
  input  logic [7:0]                    cmd_reg,
  input  logic [7:0]                    cmd_data,
  output logic                          cmd_ready,
  output logic                          chip_cs_n,
  output logic                          chip_wr_n,
  output logic                          chip_addr,
  output logic [7:0]                    chip_din,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int MAXLEN = max2(max2(ADDR_WAIT, WAIT_PSG), max2(WAIT_FM, STROBE_LEN));
  localparam int CW     = $clog2(MAXLEN + 1);

  // Counter holds remaining ticks minus one; zero is the terminal count.
  localparam logic [CW-1:0] STROBE_M1 = CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] ADDR_M1   = CW'(ADDR_WAIT - 1);
  localparam logic [CW-1:0] PSG_M1    = CW'(WAIT_PSG - 1);
  localparam logic [CW-1:0] FM_M1     = CW'(WAIT_FM - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    reg_q, data_q, reg_n, data_n;
  logic [15:0]   head;
  logic          empty;
  logic          pop;
  logic          fin;
  logic          is_psg;
  logic          dwait_zero;
  logic [CW-1:0] dwait_m1;
  logic          is_a, is_d;
  logic          cs_nxt, wr_nxt, addr_nxt;
  logic [7:0]    din_nxt;

  opn_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata ({cmd_reg, cmd_data}),
    .rdata (head),
    .empty (empty),
    .ready (cmd_ready),
    .level (level)
  );

  assign is_psg     = (reg_q < PSG_FM_BOUNDARY);
  assign dwait_zero = is_psg ? (WAIT_PSG == 0) : (WAIT_FM == 0);
  assign dwait_m1   = is_psg ? PSG_M1 : FM_M1;
  assign busy       = !empty || (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    fin       = 1'b0;
    if (state == S_IDLE) begin
      if (!empty) begin
        pop       = 1'b1;
        state_nxt = S_A_SETUP;
        cnt_nxt   = '0;
      end
    end else if (cen) begin
      if (cnt != '0) begin
        cnt_nxt = cnt - CW'(1);
      end else begin
        unique case (state)
          S_A_SETUP:  begin state_nxt = S_A_STROBE; cnt_nxt = STROBE_M1; end
          S_A_STROBE: begin state_nxt = S_A_HOLD;   cnt_nxt = '0;        end
          S_A_HOLD: begin
            if (ADDR_WAIT == 0) begin
              state_nxt = S_D_SETUP;
              cnt_nxt   = '0;
            end else begin
              state_nxt = S_A_WAIT;
              cnt_nxt   = ADDR_M1;
            end
          end
          S_A_WAIT:   begin state_nxt = S_D_SETUP;  cnt_nxt = '0;        end
          S_D_SETUP:  begin state_nxt = S_D_STROBE; cnt_nxt = STROBE_M1; end
          S_D_STROBE: begin state_nxt = S_D_HOLD;   cnt_nxt = '0;        end
          S_D_HOLD: begin
            if (dwait_zero) begin
              fin = 1'b1;
            end else begin
              state_nxt = S_D_WAIT;
              cnt_nxt   = dwait_m1;
            end
          end
          S_D_WAIT:   fin = 1'b1;
          default:    state_nxt = S_IDLE;
        endcase
        // Back-to-back: the next command is popped on the same edge the current one finishes.
        if (fin) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_A_SETUP;
            cnt_nxt   = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
    end
  end

  always_comb begin
    reg_n    = pop ? head[15:8] : reg_q;
    data_n   = pop ? head[7:0]  : data_q;
    is_a     = state_nxt inside {S_A_SETUP, S_A_STROBE, S_A_HOLD, S_A_WAIT};
    is_d     = state_nxt inside {S_D_SETUP, S_D_STROBE, S_D_HOLD, S_D_WAIT};
    cs_nxt   = !(state_nxt inside {S_A_SETUP, S_A_STROBE, S_A_HOLD,
                                   S_D_SETUP, S_D_STROBE, S_D_HOLD});
    wr_nxt   = !(state_nxt inside {S_A_STROBE, S_D_STROBE});
    addr_nxt = is_d;
    din_nxt  = is_a ? reg_n : (is_d ? data_n : chip_din);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      reg_q     <= 8'h00;
      data_q    <= 8'h00;
      chip_cs_n <= 1'b1;
      chip_wr_n <= 1'b1;
      chip_addr <= 1'b0;
      chip_din  <= 8'h00;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      reg_q     <= reg_n;
      data_q    <= data_n;
      chip_cs_n <= cs_nxt;
      chip_wr_n <= wr_nxt;
      chip_addr <= addr_nxt;
      chip_din  <= din_nxt;
      done      <= fin;
    end
  end

endmodule

// File: tb/tb_opn_write_sequencer.sv
// Directed bench for opn_write_sequencer: bus timing with cen=1 and cen toggling,
// PSG/FM wait selection, FIFO back-pressure and reset in the middle of a strobe.
module tb_opn_write_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cen = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_reg = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       chip_cs_n, chip_wr_n, chip_addr;
  logic [7:0] chip_din;
  logic       busy, done;
  logic [2:0] level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic toggle = 1'b0;

  int       cs_fall[$], cs_rise[$], wr_fall[$], wr_rise[$], done_t[$];
  logic [8:0] bus_log[$];
  logic pcs = 1'b1, pwr = 1'b1;

  opn_write_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .cmd_valid (cmd_valid),
    .cmd_reg   (cmd_reg),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .chip_cs_n (chip_cs_n),
    .chip_wr_n (chip_wr_n),
    .chip_addr (chip_addr),
    .chip_din  (chip_din),
    .busy      (busy),
    .done      (done),
    .level     (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      cen = toggle ? ~cen : 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (pcs === 1'b1 && chip_cs_n === 1'b0) cs_fall.push_back(cyc);
    if (pcs === 1'b0 && chip_cs_n === 1'b1) cs_rise.push_back(cyc);
    if (pwr === 1'b1 && chip_wr_n === 1'b0) begin
      wr_fall.push_back(cyc);
      bus_log.push_back({chip_addr, chip_din});
    end
    if (pwr === 1'b0 && chip_wr_n === 1'b1) wr_rise.push_back(cyc);
    if (done === 1'b1) done_t.push_back(cyc);
    pcs = chip_cs_n;
    pwr = chip_wr_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    cs_fall.delete(); cs_rise.delete(); wr_fall.delete(); wr_rise.delete();
    done_t.delete(); bus_log.delete();
  endtask

  // Returns the cycle number of the edge on which the command was accepted.
  task automatic push(input logic [7:0] r, input logic [7:0] d, output int t);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_reg   = r;
    cmd_data  = d;
    for (int n = 0; n < 300; n++) begin
      acc = cmd_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      @(negedge clk);
    end
    t = cyc;
    if (!acc) check("push_timeout", acc, 1'b1);
  endtask

  task automatic release_valid();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int p, p6, nd;
    int pq[5];
    logic [7:0] regs[6];
    logic [7:0] dats[6];
    regs = '{8'h0F, 8'h10, 8'h00, 8'h2B, 8'h08, 8'h09};
    dats = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", chip_cs_n, 1'b1);
    check("rst_wr_n", chip_wr_n, 1'b1);
    check("rst_addr", chip_addr, 1'b0);
    check("rst_din", chip_din, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_level", level, 3'd0);
    check("rst_ready", cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready_return", cmd_ready, 1'b1);

    // FM write with cen=1
    clear_log();
    push(8'h28, 8'hF0, p);
    release_valid();
    wait_idle(100, "t1_idle");
    check("t1_a_cs_fall", cs_fall[0], p + 1);
    check("t1_a_wr_fall", wr_fall[0], p + 2);
    check("t1_a_wr_rise", wr_rise[0], p + 4);
    check("t1_a_cs_rise", cs_rise[0], p + 5);
    check("t1_d_cs_fall", cs_fall[1], p + 11);
    check("t1_d_wr_fall", wr_fall[1], p + 12);
    check("t1_d_wr_rise", wr_rise[1], p + 14);
    check("t1_d_cs_rise", cs_rise[1], p + 15);
    check("t1_done", done_t[0], p + 39);
    check("t1_done_cnt", done_t.size(), 1);
    check("t1_bus_a", bus_log[0], 9'h028);
    check("t1_bus_d", bus_log[1], 9'h1F0);

    // PSG write
    clear_log();
    push(8'h07, 8'h38, p);
    release_valid();
    wait_idle(100, "t2_idle");
    check("t2_done", done_t[0], p + 21);
    check("t2_bus_d", bus_log[1], 9'h138);
    check("t2_done_cnt", done_t.size(), 1);

    // FIFO fill and back-pressure
    clear_log();
    for (int i = 0; i < 5; i++) push(regs[i], dats[i], pq[i]);
    check("t3_burst", pq[4], pq[0] + 4);
    check("t3_full_ready", cmd_ready, 1'b0);
    check("t3_full_level", level, 3'd4);
    push(regs[5], dats[5], p6);
    release_valid();
    check("t3_sixth_push", p6, pq[0] + 22);
    wait_idle(400, "t3_idle");
    check("t3_done_cnt", done_t.size(), 6);
    check("t3_done0", done_t[0], pq[0] + 21);
    check("t3_fm_gap", done_t[1] - done_t[0], 38);
    check("t3_psg_gap", done_t[2] - done_t[1], 20);
    for (int k = 1; k < 6; k++) check($sformatf("t3_b2b%0d", k), cs_fall[2*k], done_t[k-1]);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_bus_a%0d", i), bus_log[2*i], {1'b0, regs[i]});
      check($sformatf("t3_bus_d%0d", i), bus_log[2*i+1], {1'b1, dats[i]});
    end
    check("t3_level_end", level, 3'd0);

    // cen toggling every clk
    clear_log();
    toggle = 1'b1;
    push(8'h05, 8'h11, p);
    release_valid();
    wait_idle(200, "t4_idle");
    toggle = 1'b0;
    check("t4_a_strobe", wr_rise[0] - wr_fall[0], 4);
    check("t4_a_wait", cs_fall[1] - cs_rise[0], 12);
    check("t4_d_strobe", wr_rise[1] - wr_fall[1], 4);
    check("t4_d_wait", done_t[0] - cs_rise[1], 12);
    check("t4_bus_a", bus_log[0], 9'h005);
    check("t4_bus_d", bus_log[1], 9'h111);

    // reset during data strobe
    clear_log();
    push(8'h30, 8'h55, p);
    release_valid();
    nd = 0;
    while (!(chip_addr === 1'b1 && chip_wr_n === 1'b0) && nd < 100) begin
      @(posedge clk);
      #1;
      nd++;
    end
    check("t5_reach_dstrobe", chip_wr_n, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_wr_n", chip_wr_n, 1'b1);
    check("t5_cs_n", chip_cs_n, 1'b1);
    check("t5_level", level, 3'd0);
    check("t5_ready", cmd_ready, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_ready_return", cmd_ready, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("t5_no_done", done_t.size(), 0);
    clear_log();
    push(8'h10, 8'h22, p);
    release_valid();
    wait_idle(100, "t5_idle");
    check("t5_new_done", done_t[0], p + 39);
    check("t5_new_bus_a", bus_log[0], 9'h010);
    check("t5_new_bus_d", bus_log[1], 9'h122);
    check("t5_new_done_cnt", done_t.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
